// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline hazard/stall controller for the 5-stage core
// Owns PC/IF-ID write enables, ID bubble, IF flush, d-cache freeze, perf counters and timeout flag.
module hazard_stall_ctrl #(
   parameter int CNT_W   = 32,
   parameter int WAIT_W  = 8,
   parameter int TIMEOUT = 200
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ID_rs1_i,
   input  logic [4:0]       ID_rs2_i,
   input  logic             ID_use_rs1_i,
   input  logic             ID_use_rs2_i,
   input  logic             EX_MemRead_i,
   input  logic [4:0]       EX_Rd_i,
   input  logic             ID_branch_taken_i,
   input  logic             MEM_access_i,
   input  logic             dcache_ready_i,
   output logic             dcache_req_o,
   output logic             pipe_stall_o,
   output logic             PC_write_o,
   output logic             IF_ID_write_o,
   output logic             ID_bubble_o,
   output logic             IF_flush_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] lu_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t            state;
   state_t            stateNext;
   logic              loadUse;
   logic [WAIT_W-1:0] waitCnt;

   // A load in EX writing x0 never creates a real dependency.
   always_comb begin
      loadUse = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
                ((ID_use_rs1_i && (ID_rs1_i == EX_Rd_i)) ||
                 (ID_use_rs2_i && (ID_rs2_i == EX_Rd_i)));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= RUN;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         RUN: begin
            if (MEM_access_i && !dcache_ready_i) begin
               stateNext = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (dcache_ready_i) begin
               stateNext = RUN;
            end
         end
         default: stateNext = RUN;
      endcase
   end

   // Freeze beats load-use, which beats a taken branch; reset forces a free-running pipe.
   always_comb begin
      dcache_req_o  = 1'b0;
      pipe_stall_o  = 1'b0;
      PC_write_o    = 1'b1;
      IF_ID_write_o = 1'b1;
      ID_bubble_o   = 1'b0;
      IF_flush_o    = 1'b0;
      if (!rst_i) begin
         dcache_req_o = ((state == RUN) && MEM_access_i) || (state == MEM_WAIT);
         pipe_stall_o = dcache_req_o && !dcache_ready_i;
         if (pipe_stall_o) begin
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
         end else if (loadUse) begin
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            ID_bubble_o   = 1'b1;
         end else if (ID_branch_taken_i) begin
            IF_flush_o    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_o <= '0;
         lu_cnt_o    <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (pipe_stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         end
         if (ID_bubble_o && (lu_cnt_o != '1)) begin
            lu_cnt_o <= lu_cnt_o + CNT_W'(1);
         end
         if (IF_flush_o && (flush_cnt_o != '1)) begin
            flush_cnt_o <= flush_cnt_o + CNT_W'(1);
         end
      end
   end

   // The timeout only reports; the request stays up until the cache answers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         waitCnt   <= '0;
         timeout_o <= 1'b0;
      end else if (pipe_stall_o) begin
         if (waitCnt != '1) begin
            waitCnt <= waitCnt + WAIT_W'(1);
         end
         if (waitCnt == TIMEOUT_LAST) begin
            timeout_o <= 1'b1;
         end
      end else begin
         waitCnt <= '0;
      end
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It sits beside the forwarding logic and owns every pipeline-register write-enable and flush. It does three things: freezes the whole pipeline while the MEM-stage data-cache access is outstanding, inserts one bubble on a load-use hazard, and flushes IF on a taken branch resolved in ID. It also keeps saturating performance counters and a sticky cache-timeout flag.

## Interface
- CNT_W, 32, width of performance counters
- WAIT_W, 8, width of per-access wait counter
- TIMEOUT, 200, consecutive stall cycles before timeout_o sets (1 ≤ TIMEOUT ≤ 2^WAIT_W−1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- ID_rs1_i, ID_rs2_i  in  5  source registers of the instruction in ID
- ID_use_rs1_i, ID_use_rs2_i  in  1  instruction in ID actually reads rs1 / rs2
- EX_MemRead_i  in  1  instruction in EX is a load
- EX_Rd_i  in  5  destination of the instruction in EX
- ID_branch_taken_i  in  1  branch in ID resolved taken
- MEM_access_i  in  1  valid load/store in MEM
- dcache_ready_i  in  1  data cache completes the access this cycle
- dcache_req_o  out  1  access request to the data cache
- pipe_stall_o  out  1  freeze all pipeline registers and PC
- PC_write_o, IF_ID_write_o  out  1  write enables
- ID_bubble_o  out  1  zero control fields into ID/EX
- IF_flush_o  out  1  clear IF/ID
- timeout_o  out  1  sticky cache-timeout flag
- stall_cnt_o, lu_cnt_o, flush_cnt_o  out  CNT_W  counts of stall cycles, load-use bubbles and IF flushes

## Operation
- FSM states: RUN, MEM_WAIT.
  - RUN→MEM_WAIT when MEM_access_i=1 and dcache_ready_i=0.
  - MEM_WAIT→RUN when dcache_ready_i=1.
  - Otherwise the state holds.
- dcache_req_o = (RUN & MEM_access_i) | MEM_WAIT.
- pipe_stall_o = dcache_req_o & ~dcache_ready_i. A hit (ready in the request cycle) causes no stall.
- Load-use hazard: lu = EX_MemRead_i & EX_Rd_i≠0 & ((ID_use_rs1_i & ID_rs1_i==EX_Rd_i) | (ID_use_rs2_i & ID_rs2_i==EX_Rd_i)).
- Output priority, highest first:
  1. pipe_stall_o=1: PC_write=0, IF_ID_write=0, ID_bubble=0, IF_flush=0. The pipeline is frozen and no bubble is injected.
  2. lu=1: PC_write=0, IF_ID_write=0, ID_bubble=1, IF_flush=0. A taken branch is ignored and re-resolved next cycle.
  3. ID_branch_taken_i=1: PC_write=1, IF_ID_write=1, IF_flush=1.
  4. Otherwise: PC_write=1, IF_ID_write=1, rest 0.
- Counters increment per cycle and saturate at all-ones:
  - stall_cnt_o when pipe_stall_o=1.
  - lu_cnt_o when ID_bubble_o=1.
  - flush_cnt_o when IF_flush_o=1.
- wait_cnt (internal, WAIT_W bits):
  - Cleared on any cycle with pipe_stall_o=0.
  - Incremented, saturating, on cycles with pipe_stall_o=1.
  - timeout_o sets at the edge ending a cycle where pipe_stall_o=1 and wait_cnt==TIMEOUT−1.
  - timeout_o clears only on reset. The controller keeps waiting after a timeout and never drops the request.

## Timing
- Reset (rst_i=1 at an edge): state=RUN, wait_cnt=0, timeout_o=0, all counters=0.
- While rst_i=1, combinational outputs are forced: dcache_req_o=0, pipe_stall_o=0, ID_bubble_o=0, IF_flush_o=0, PC_write_o=1, IF_ID_write_o=1.
- Reset during MEM_WAIT aborts the wait. On the first cycle after reset the FSM is in RUN and outputs follow the current inputs.
- All control outputs are combinational from the current state and inputs, with zero latency. State, counters and timeout update on the rising edge.
- Miss of N wait cycles (ready first seen in cycle N+1 of the request): pipe_stall_o=1 for exactly N cycles, dcache_req_o=1 for N+1 cycles, stall_cnt_o increases by N.
- Back-to-back accesses: if MEM_access_i=1 in the cycle after MEM_WAIT→RUN, a new request issues immediately.
- A load-use bubble lasts exactly one cycle, because the load moves to MEM. If that load then misses, the freeze takes priority from that cycle on.
- Simultaneous miss, load-use and branch: only the freeze applies. The lower-priority actions are re-evaluated after the freeze ends.

## Test plan
- Hit: MEM_access_i=1 and dcache_ready_i=1 in the same cycle → dcache_req_o=1, pipe_stall_o=0, stall_cnt_o unchanged, state stays RUN.
- Miss, 5-cycle latency: MEM_access_i=1, ready low for 5 cycles then high → pipe_stall_o high for 5 cycles, PC_write_o=0 throughout, stall_cnt_o=5, returns to RUN.
- Load-use: EX_MemRead_i=1, EX_Rd_i=5, ID_rs2_i=5, ID_use_rs2_i=1 → one cycle of ID_bubble_o=1, PC_write_o=0, IF_ID_write_o=0, lu_cnt_o=1.
  - Same stimulus with EX_Rd_i=0 → no bubble.
- Priority: a miss stall, lu=1 and ID_branch_taken_i=1 together → ID_bubble_o=0, IF_flush_o=0.
  - Once ready rises: branch alone → IF_flush_o=1 for 1 cycle, flush_cnt_o=1.
- Timeout with TIMEOUT=4: ready held low for 10 cycles → timeout_o rises after the 4th stall edge and stays high after ready rises.
  - rst_i pulse → timeout_o=0, counters 0, state RUN.
- Saturation with CNT_W=3: 9 miss-stall cycles → stall_cnt_o stops at 7.
